// File: rtl/count_mod_ud_pkg.sv
// Shared constants for the modulo up/down counter family: end-of-range
// mode encodings and the parameter legality check used at elaboration.
package count_mod_ud_pkg;

  localparam int COUNT_WRAP = 0;
  localparam int COUNT_SAT  = 1;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  // A modulus is usable when it spans at least two values and its
  // top value MODULUS-1 still fits in the counter width.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (width >= 1) && (width <= 16) &&
           (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/count_mod_ud_next.sv
// Combinational next-value generator for the modulo counter: increment,
// decrement, wrap or saturate at the range end, and clamped parallel load.
module count_mod_next
  import count_mod_ud_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = COUNT_WRAP
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ld_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             at_term_o,
  output logic             ld_oor_o
);

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
  localparam bit               SAT_EN  = (SATURATE == COUNT_SAT);

  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;

  assign inc_val = q_i + WIDTH'(1);
  assign dec_val = q_i - WIDTH'(1);

  // Terminal value depends on direction: top of range going up, zero going down.
  assign at_term_o = up_i ? (q_i == TOP_VAL) : (q_i == '0);

  // Load values are compared against the full modulus in 32 bits so a
  // modulus of exactly 2^WIDTH never flags a load as out of range.
  assign ld_oor_o = (32'(d_i) >= MODULUS);

  // Select the value the counter takes on a counting or loading edge.
  always_comb begin
    nxt_o = q_i;
    if (ld_i) begin
      nxt_o = ld_oor_o ? TOP_VAL : d_i;
    end else if (up_i) begin
      if (at_term_o) begin
        nxt_o = SAT_EN ? q_i : '0;
      end else begin
        nxt_o = inc_val;
      end
    end else begin
      if (at_term_o) begin
        nxt_o = SAT_EN ? q_i : TOP_VAL;
      end else begin
        nxt_o = dec_val;
      end
    end
  end

endmodule

// File: rtl/count_mod_ud.sv
// Modulo-N up/down counter with clock enable, clamped parallel load,
// cascadable terminal count, sticky overflow and a load-error pulse.
module count_mod_ud
  import count_mod_ud_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = COUNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             ld_err
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_param
    $error("count_mod_ud: MODULUS=%0d illegal for WIDTH=%0d", MODULUS, WIDTH);
  end

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             lderr_q;
  logic             lderr_d;

  logic [WIDTH-1:0] nxt_val;
  logic             at_term;
  logic             ld_oor;

  count_mod_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .q_i       (cnt_q),
    .d_i       (d),
    .ld_i      (ld),
    .up_i      (up),
    .nxt_o     (nxt_val),
    .at_term_o (at_term),
    .ld_oor_o  (ld_oor)
  );

  // Terminal count is only meaningful on a real counting cycle; it feeds
  // the next stage's ce, so it must drop during reset, hold and load.
  assign tc = ce & ~ld & ~rst & at_term;

  // Next state: hold when disabled; overflow set beats clear, and clear
  // works even while the counter is held.
  always_comb begin
    cnt_d   = ce ? nxt_val : cnt_q;
    lderr_d = ce & ld & ld_oor;
    ovf_d   = tc | (ovf_q & ~clr_ovf);
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      lderr_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      lderr_q <= lderr_d;
    end
  end

  assign q      = cnt_q;
  assign ovf    = ovf_q;
  assign ld_err = lderr_q;

endmodule
